// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared defaults and pipeline stage type for the memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int unsigned MEM_ADDR_W      = 16;
    localparam int unsigned MEM_DATA_W      = 16;
    localparam int unsigned MEM_LATENCY     = 4;
    localparam int unsigned MEM_MAX_LATENCY = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic                  err;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_stage_t;

endpackage

`default_nettype wire

// File: rtl/mem_lat_pipe.sv
// ============================================================================
//  Module   : mem_lat_pipe
//  Brief    : LATENCY-stage response shift pipeline with a global hold.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lat_pipe
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_i,
    input  mem_stage_t stage_i,
    output mem_stage_t stage_o
);

    mem_stage_t stage_q [LATENCY];
    mem_stage_t stage_d [LATENCY];

    always_comb begin
        stage_d = stage_q;
        if (!hold_i) begin
            stage_d[0] = stage_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Clearing every field, not just valid, keeps the rsp_* outputs at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module   : mem_responder
//  Brief    : Fixed-latency pipelined memory responder with backpressure.
//             Optional misalignment check enabled by MEM_ALIGN_CHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
`ifdef MEM_ALIGN_CHK_EN
    output logic              rsp_err,
`endif
    output logic [DATA_W-1:0] rsp_rdata
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              stall;
    logic              accept;
    logic              misaligned;
    logic [ADDR_W-2:0] word_idx;
    mem_stage_t        pipe_in;
    mem_stage_t        pipe_out;

    assign stall     = pipe_out.valid & ~rsp_ready;
    assign req_ready = rst_n & ~stall;
    assign accept    = req_valid & req_ready;
    assign word_idx  = req_addr[ADDR_W-1:1];

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = req_addr[0];
    assign rsp_err    = pipe_out.err;
`else
    logic unused_sig;
    assign misaligned = 1'b0;
    assign unused_sig = ^{req_addr[0], pipe_out.err};
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && req_wr && !misaligned) begin
            mem_q[word_idx] <= req_wdata;
        end
    end

    // Reads sample the array before this edge's update, so they see all prior writes.
    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = accept;
        pipe_in.wr    = accept & req_wr;
        pipe_in.err   = accept & misaligned;
        if (accept && !req_wr && !misaligned) begin
            pipe_in.rdata = MEM_DATA_W'(mem_q[word_idx]);
        end
    end

    mem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (stall),
        .stage_i (pipe_in),
        .stage_o (pipe_out)
    );

    assign rsp_valid = pipe_out.valid;
    assign rsp_wr    = pipe_out.wr;
    assign rsp_rdata = DATA_W'(pipe_out.rdata);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module   : tb_mem_responder
//  Brief    : Self-checking bench; DUT0 LATENCY=4, DUT1 LATENCY=1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  age;
        logic        wr;
        logic        err;
        logic        known;
        logic [15:0] rdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_wr    [2];
    logic [15:0] rsp_rdata [2];
`ifdef MEM_ALIGN_CHK_EN
    logic        rsp_err   [2];
`endif

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_wr(rsp_wr[0]),
`ifdef MEM_ALIGN_CHK_EN
        .rsp_err(rsp_err[0]),
`endif
        .rsp_rdata(rsp_rdata[0])
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_wr(rsp_wr[1]),
`ifdef MEM_ALIGN_CHK_EN
        .rsp_err(rsp_err[1]),
`endif
        .rsp_rdata(rsp_rdata[1])
    );

    // Reference model: each accepted request waits LATENCY un-stalled cycles in an
    // in-order queue; the memory is a plain array of the low 64 words.
    int          lat [2] = '{LAT0, LAT1};
    ent_t        pq [2][$];
    logic [15:0] mref [2][64];
    bit          mkn  [2][64];

    int checks = 0;
    int errors = 0;

    logic        o_rdy, o_rv, o_rw, o_err, e_rdy, e_rv, e_rw, e_err, e_known;
    logic [15:0] o_rd, e_rd;
    logic [19:0] o_vec, e_vec, e_mask;

    task automatic step(input int s, input logic rn, input logic v, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd, input logic rr);
        bit   vis [2];
        ent_t t;
        int   w;
        bit   stl;
        @(negedge clk);
        rst_n = rn;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = (k == s) && v;
            req_wr[k]    = wr;
            req_addr[k]  = addr;
            req_wdata[k] = wd;
            rsp_ready[k] = (k == s) ? rr : 1'b1;
            vis[k] = (pq[k].size() > 0) && (int'(pq[k][0].age) >= lat[k]);
        end
        #1;
        e_rv = vis[s]; e_rw = 1'b0; e_err = 1'b0; e_rd = 16'h0; e_known = 1'b1;
        if (vis[s]) begin
            t = pq[s][0];
            e_rw = t.wr; e_err = t.err; e_rd = t.rdata; e_known = t.known;
        end
        e_rdy = rn && !(vis[s] && !rr);
        o_rdy = req_ready[s]; o_rv = rsp_valid[s]; o_rw = rsp_wr[s]; o_rd = rsp_rdata[s];
`ifdef MEM_ALIGN_CHK_EN
        o_err = rsp_err[s];
`else
        o_err = 1'b0;
`endif
        o_vec  = {o_rdy, o_rv, o_rw, o_err, o_rd};
        e_vec  = {e_rdy, e_rv, e_rw, e_err, e_rd};
        e_mask = e_known ? 20'hFFFFF : 20'hF0000;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pq[k].delete();
            end else begin
                stl = vis[k] && !rsp_ready[k];
                if (vis[k] && rsp_ready[k]) pq[k].delete(0);
                if (!stl) begin
                    for (int j = 0; j < pq[k].size(); j++) begin
                        t = pq[k][j];
                        t.age = t.age + 8'd1;
                        pq[k][j] = t;
                    end
                end
                if (req_valid[k] && !stl) begin
                    w = int'(req_addr[k][6:1]);
                    t.age = 8'd1; t.wr = req_wr[k]; t.err = ALIGN && req_addr[k][0];
                    t.known = 1'b1; t.rdata = 16'h0;
                    if (req_wr[k]) begin
                        if (!t.err) begin
                            mref[k][w] = req_wdata[k];
                            mkn[k][w]  = 1'b1;
                        end
                    end else if (!t.err) begin
                        t.known = mkn[k][w];
                        t.rdata = mref[k][w];
                    end
                    pq[k].push_back(t);
                end
            end
        end
    endtask

    task automatic test_reset();
        step(0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h5555, 1'b1);
        checks++;
        if (o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", o_rdy);
        end
        for (int s = 0; s < 2; s++) begin
            step(s, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%h exp=%h", s, o_vec, e_vec);
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      step(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
            else if (i == 1) step(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
            else             step(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL write_read cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (i == 4) begin
                checks++;
                if ({o_rv, o_rw, o_rd} !== {1'b1, 1'b1, 16'h0000}) begin
                    errors++;
                    $display("FAIL write_ack got=%h exp=%h", {o_rv, o_rw, o_rd}, {1'b1, 1'b1, 16'h0});
                end
            end
            if (i == 5) begin
                checks++;
                if ({o_rv, o_rw, o_rd} !== {1'b1, 1'b0, 16'hBEEF}) begin
                    errors++;
                    $display("FAIL read_beef got=%h exp=%h", {o_rv, o_rw, o_rd}, {1'b1, 1'b0, 16'hBEEF});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          rc = 0;
        logic [15:0] rd_d [4];
        int          rd_c [4];
        for (int j = 0; j < 4; j++) begin rd_d[j] = 16'h0; rd_c[j] = -100; end
        for (int i = 0; i < 16; i++) begin
            if (i < 4)      step(0, 1'b1, 1'b1, 1'b1, 16'(32'h20 + 2*i), 16'(i + 1), 1'b1);
            else if (i < 8) step(0, 1'b1, 1'b1, 1'b0, 16'(32'h20 + 2*(i-4)), 16'h0, 1'b1);
            else            step(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (o_rv === 1'b1 && o_rw === 1'b0 && rc < 4) begin
                rd_d[rc] = o_rd; rd_c[rc] = i; rc++;
            end
        end
        checks++;
        if (rc != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=4", rc);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rd_d[j] !== 16'(j + 1) || rd_c[j] != rd_c[0] + j) begin
                errors++;
                $display("FAIL b2b_order idx=%0d got=%h@%0d exp=%h@%0d", j, rd_d[j], rd_c[j], 16'(j+1), rd_c[0]+j);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        rr;
        int          dc = 0;
        logic [15:0] got [4];
        for (int i = 0; i < 15; i++) begin
            rr = !(i >= 4 && i <= 6);
            if (i < 4) step(0, 1'b1, 1'b1, 1'b0, 16'(32'h20 + 2*i), 16'h0, rr);
            else       step(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, rr);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL bp cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (i >= 4 && i <= 6) begin
                checks++;
                if ({o_rdy, o_rv, o_rd} !== {1'b0, 1'b1, 16'h0001}) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {o_rdy, o_rv, o_rd}, {1'b0, 1'b1, 16'h0001});
                end
            end
            if (o_rv === 1'b1 && rr && dc < 4) begin got[dc] = o_rd; dc++; end
        end
        checks++;
        if (dc != 4 || got[0] !== 16'h1 || got[1] !== 16'h2 || got[2] !== 16'h3 || got[3] !== 16'h4) begin
            errors++;
            $display("FAIL bp_drain got=%0d resp exp=4 in order 1..4", dc);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0)      step(0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1);
            else if (i < 4)  step(0, 1'b1, 1'b1, 1'b0, 16'(32'h20 + 2*(i-1)), 16'h0, 1'b1);
            else if (i == 4) step(0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hDEAD, 1'b1);
            else if (i == 10) step(0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1);
            else             step(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (i >= 5 && i <= 9) begin
                checks++;
                if (o_rv !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_flush cyc=%0d got=%b exp=0", i, o_rv);
                end
            end
            if (i > 10 && o_rv === 1'b1) begin
                seen++;
                checks++;
                if (o_rd !== 16'h1234) begin
                    errors++;
                    $display("FAIL rst_keep got=%h exp=1234", o_rd);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL rst_resp_count got=%0d exp=1", seen);
        end
    endtask

    task automatic test_misaligned();
`ifdef MEM_ALIGN_CHK_EN
        logic [16:0] exp_rd = {1'b0, 16'hBEEF};
`else
        logic [16:0] exp_rd = {1'b0, 16'hAAAA};
`endif
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      step(0, 1'b1, 1'b1, 1'b1, 16'h0011, 16'hAAAA, 1'b1);
            else if (i == 1) step(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
            else             step(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL misalign cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (i == 4) begin
                checks++;
                if ({o_rv, o_rw, o_err} !== {1'b1, 1'b1, ALIGN}) begin
                    errors++;
                    $display("FAIL misalign_ack got=%b exp=%b", {o_rv, o_rw, o_err}, {1'b1, 1'b1, ALIGN});
                end
            end
            if (i == 5) begin
                checks++;
                if ({o_err, o_rd} !== exp_rd) begin
                    errors++;
                    $display("FAIL misalign_read got=%h exp=%h", {o_err, o_rd}, exp_rd);
                end
            end
        end
    endtask

    task automatic test_lat1();
        int   acc = 0;
        int   del = 0;
        logic rr;
        step(1, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h7777, 1'b1);
        step(1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
        step(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checks++;
        if ({o_rv, o_rw, o_rd} !== {1'b1, 1'b0, 16'h7777}) begin
            errors++;
            $display("FAIL lat1_read got=%h exp=%h", {o_rv, o_rw, o_rd}, {1'b1, 1'b0, 16'h7777});
        end
        for (int i = 0; i < 20; i++) begin
            rr = (i % 2 == 0) || (i >= 16);
            step(1, 1'b1, i < 16, 1'b0, 16'h0030, 16'h0, rr);
            checks++;
            if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                errors++;
                $display("FAIL lat1_toggle cyc=%0d got=%h exp=%h", i, o_vec, e_vec);
            end
            if (i < 16 && o_rdy === 1'b1) acc++;
            if (o_rv === 1'b1 && rr) begin
                del++;
                checks++;
                if (o_rd !== 16'h7777) begin
                    errors++;
                    $display("FAIL lat1_data cyc=%0d got=%h exp=7777", i, o_rd);
                end
            end
        end
        checks++;
        if (acc != del || acc == 0) begin
            errors++;
            $display("FAIL lat1_lost accepted=%0d delivered=%0d", acc, del);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 160; i++) begin
                if (i < 148)
                    step(s, 1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 127)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
                else
                    step(s, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
                checks++;
                if (((o_vec ^ e_vec) & e_mask) !== 20'h0) begin
                    errors++;
                    $display("FAIL random dut=%0d cyc=%0d got=%h exp=%h", s, i, o_vec, e_vec);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_wr[k] = 1'b0; req_addr[k] = 16'h0;
            req_wdata[k] = 16'h0; rsp_ready[k] = 1'b1;
            for (int w = 0; w < 64; w++) begin mref[k][w] = 16'h0; mkn[k][w] = 1'b0; end
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_misaligned();
        test_lat1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
